// File: rtl/bmi_issue_stage.sv
// Issue stage for the rotate unit: 2-entry in-order request FIFO, op decode, registered issue.
// Optional BMI_ISSUE_ROTL_EN: ROTL is converted to an equivalent right-rotate; otherwise it is dropped.
module bmi_issue_stage #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned SHIFT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_shift,
    input  logic                  issue_stall,
    output logic                  rot_enable,
    output logic [DATA_WIDTH-1:0] rot_a,
    output logic [DATA_WIDTH-1:0] rot_shift,
    output logic                  err,
    output logic [1:0]            occupancy
);

    typedef enum logic [1:0] {
        OP_ROTR = 2'b00,
        OP_ROTL = 2'b01,
        OP_PASS = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    op_e                  op_mem [2];
    logic [DATA_WIDTH-1:0] a_mem  [2];
    logic [SHIFT_BITS-1:0] sh_mem [2];

    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  push;
    logic                  pop;

    op_e                   head_op;
    logic [DATA_WIDTH-1:0] head_a;
    logic [SHIFT_BITS-1:0] head_shift;
    logic                  issue;
    logic                  illegal;
    logic [SHIFT_BITS-1:0] next_shift;

    logic [SHIFT_BITS-1:0] shift_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic                  enable_q;
    logic                  err_q;

    // Only the low SHIFT_BITS of the shift operand carry meaning.
    logic unused_shift_bits;
    assign unused_shift_bits = ^in_shift[DATA_WIDTH-1:SHIFT_BITS];

    assign in_ready  = (count != 2'd2) && !rst;
    assign push      = in_valid && in_ready;
    // Pop decision uses the pre-edge count, so a fresh entry cannot bypass to issue.
    assign pop       = (count != 2'd0) && !issue_stall;

    assign head_op    = op_mem[rd_ptr];
    assign head_a     = a_mem[rd_ptr];
    assign head_shift = sh_mem[rd_ptr];

    always_comb begin
        issue      = 1'b0;
        illegal    = 1'b0;
        next_shift = head_shift;
        case (head_op)
            OP_ROTR: begin
                issue      = 1'b1;
                next_shift = head_shift;
            end
            OP_PASS: begin
                issue      = 1'b1;
                next_shift = '0;
            end
`ifdef BMI_ISSUE_ROTL_EN
            OP_ROTL: begin
                issue      = 1'b1;
                next_shift = SHIFT_BITS'((32'(DATA_WIDTH) - 32'(head_shift)) % 32'(DATA_WIDTH));
            end
`endif
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr] <= op_e'(in_op);
            a_mem[wr_ptr]  <= in_a;
            sh_mem[wr_ptr] <= in_shift[SHIFT_BITS-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q <= 1'b0;
            err_q    <= 1'b0;
            a_q      <= '0;
            shift_q  <= '0;
        end else begin
            enable_q <= pop && issue;
            err_q    <= pop && illegal;
            if (pop && issue) begin
                a_q     <= head_a;
                shift_q <= next_shift;
            end
        end
    end

    assign rot_enable = enable_q;
    assign err        = err_q;
    assign rot_a      = a_q;
    assign rot_shift  = DATA_WIDTH'(shift_q);
    assign occupancy  = count;

endmodule
